hazard_control_unit: RTL

Stall and flush controller for the 5-stage pipeline, the counterpart to the EX-stage forwarding path. Forwarding covers the cases where a result can be bypassed; this block handles the cases where it cannot. It detects load-use hazards in ID and holds the front end for a programmable number of cycles. It also redirects and flushes on a taken branch resolved at EX/MEM, and keeps saturating stall and flush statistics. It sits beside the ID stage and drives the PC, IF/ID, ID/EX and EX/MEM register controls.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/hazard_control_unit_sat_counter.sv | 24 ++
 rtl/hazard_control_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline control types: hazard FSM states, register-zero constant
// and the bundle of per-stage flush controls.
package pipeline_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hcu_state_t;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic ex_mem;
    } flush_ctl_t;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter used for the stall / flush statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller: holds the front end on load-use hazards for a
// programmable number of cycles, redirects and flushes on taken branches
// resolved in MEM, and keeps saturating stall / flush statistics.
module hazard_control_unit
    import pipeline_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 2,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_RegisterRs1,
    input  logic [4:0]       IF_ID_RegisterRs2,
    input  logic             IF_ID_UsesRs1,
    input  logic             IF_ID_UsesRs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic             EX_MEM_Branch,
    input  logic             EX_MEM_Zero,
    input  logic             MemBusy,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents
);

    // Remaining bubbles after the one inserted on hazard detection.
    localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL_CYCLES - 1);

    hcu_state_t r_state;
    hcu_state_t w_state_next;
    logic [3:0] r_remain;
    logic [3:0] w_remain_next;
    logic       w_hazard;
    logic       w_taken;
    logic       w_stall_inc;
    logic       w_flush_inc;
    flush_ctl_t w_flush;

    assign w_hazard = ID_EX_MemRead && (ID_EX_RegisterRd != REG_ZERO) &&
                      ((IF_ID_UsesRs1 && (ID_EX_RegisterRd == IF_ID_RegisterRs1)) ||
                       (IF_ID_UsesRs2 && (ID_EX_RegisterRd == IF_ID_RegisterRs2)));
    assign w_taken  = EX_MEM_Branch && EX_MEM_Zero;

    // State and bubble-count registers; reset discards any stall in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= RUN;
            r_remain <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_remain <= w_remain_next;
        end
    end

    // Next-state: a memory freeze holds everything, a taken branch aborts stalls.
    always_comb begin
        w_state_next  = r_state;
        w_remain_next = r_remain;
        if (MemBusy) begin
            w_state_next  = r_state;
        end else if (w_taken) begin
            w_state_next  = RUN;
            w_remain_next = 4'd0;
        end else if (r_state == STALL) begin
            w_remain_next = r_remain - 4'd1;
            if (r_remain == 4'd1) begin
                w_state_next = RUN;
            end
        end else if (w_hazard && (LOAD_STALL_CYCLES > 1)) begin
            w_state_next  = STALL;
            w_remain_next = STALL_INIT;
        end
    end

    // Outputs in priority order: reset, freeze, redirect, stall, normal run.
    always_comb begin
        PCWrite      = 1'b0;
        PCSrc        = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b0;
        w_flush      = '0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        if (reset) begin
            ID_EX_Bubble = 1'b1;
        end else if (MemBusy) begin
            PCWrite      = 1'b0;
        end else if (w_taken) begin
            PCSrc        = 1'b1;
            PCWrite      = 1'b1;
            IF_ID_Write  = 1'b1;
            w_flush      = '{if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1};
            w_flush_inc  = 1'b1;
        end else if ((r_state == STALL) || w_hazard) begin
            ID_EX_Bubble = 1'b1;
            w_stall_inc  = 1'b1;
        end else begin
            PCWrite      = 1'b1;
            IF_ID_Write  = 1'b1;
        end
    end

    assign IF_ID_Flush  = w_flush.if_id;
    assign ID_EX_Flush  = w_flush.id_ex;
    assign EX_MEM_Flush = w_flush.ex_mem;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (FlushEvents)
    );

endmodule
